// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 frame controller for the on-chip register peripheral
//
// Sends one 16-bit frame per accepted request, MSB first: {data[7:0], addr[6:0], rw}.
// SCLK idles low and the peripheral samples copi on the rising edge.
//
// Optional build macro: SPI_CTRL_QUEUE_EN
//   defined   - one-entry request holding register; a request can be accepted mid-frame
//               and starts back-to-back after the inter-frame gap
//   undefined - no holding register; req_ready only in IDLE
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted on the clk edge where req_valid & req_ready
//   req_addr   in   [6:0] register address
//   req_data   in   [7:0] write data
//   req_rw     in   rw bit, 1 = write
//   sclk       out  SPI clock (registered)
//   ncs        out  chip select, active low (registered)
//   copi       out  serial data out (registered)
//   busy       out  high from acceptance until end of the inter-frame gap
//   done       out  one-cycle pulse in the cycle ncs returns high

module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    input  logic       req_rw,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    output logic       busy,
    output logic       done
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // The phase counter runs 0..P-1, so $clog2(P) bits hold its largest value.
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = (IDLE_GAP > 0) ? CW'(IDLE_GAP - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [15:0]   shreg, shreg_d;
    logic          sclk_q, sclk_d;
    logic          ncs_q, ncs_d;
    logic          copi_q, copi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    // Holds req_ready low while in reset and for the first edge after release.
    logic          rst_done;

    logic [15:0]   frame_in;
    logic [15:0]   launch_frame;
    logic          launch;
    logic          accept;

`ifdef SPI_CTRL_QUEUE_EN
    logic          hold_full, hold_full_d;
    logic [15:0]   hold_frame, hold_frame_d;

    assign req_ready = rst_done & ~hold_full;
`else
    assign req_ready = rst_done & (state == ST_IDLE);
`endif

    assign frame_in = {req_data, req_addr, req_rw};
    assign accept   = req_valid & req_ready;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        sclk_d       = sclk_q;
        ncs_d        = ncs_q;
        copi_d       = copi_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        launch       = 1'b0;
        launch_frame = frame_in;
`ifdef SPI_CTRL_QUEUE_EN
        hold_full_d  = hold_full;
        hold_frame_d = hold_frame;
`endif

        case (state)
            ST_IDLE: begin
`ifdef SPI_CTRL_QUEUE_EN
                if (hold_full) begin
                    launch       = 1'b1;
                    launch_frame = hold_frame;
                    hold_full_d  = 1'b0;
                end else if (accept) begin
                    launch = 1'b1;
                end
`else
                if (accept) begin
                    launch = 1'b1;
                end
`endif
            end

            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit, except after the 16th
                        // bit where copi keeps frame[0] through HOLD.
                        sclk_d = 1'b0;
                        if (bit_cnt != 4'd15) begin
                            shreg_d = {shreg[14:0], 1'b0};
                            copi_d  = shreg[14];
                        end
                    end else if (bit_cnt == 4'd15) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        sclk_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_d  = '0;
                    ncs_d  = 1'b1;
                    copi_d = 1'b0;
                    done_d = 1'b1;
                    if (IDLE_GAP == 0) begin
                        state_d = ST_IDLE;
`ifdef SPI_CTRL_QUEUE_EN
                        busy_d  = hold_full | accept;
`else
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
`ifdef SPI_CTRL_QUEUE_EN
                    if (hold_full) begin
                        launch       = 1'b1;
                        launch_frame = hold_frame;
                        hold_full_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = accept;
                    end
`else
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            state_d   = ST_SETUP;
            cnt_d     = '0;
            bit_cnt_d = '0;
            shreg_d   = launch_frame;
            ncs_d     = 1'b0;
            sclk_d    = 1'b0;
            copi_d    = launch_frame[15];
            busy_d    = 1'b1;
        end

`ifdef SPI_CTRL_QUEUE_EN
        // An accept that did not launch directly from an empty IDLE goes to the hold slot.
        if (accept && !(state == ST_IDLE && !hold_full)) begin
            hold_full_d  = 1'b1;
            hold_frame_d = frame_in;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sclk_q   <= 1'b0;
            ncs_q    <= 1'b1;
            copi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            sclk_q   <= sclk_d;
            ncs_q    <= ncs_d;
            copi_q   <= copi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rst_done <= 1'b1;
        end
    end

`ifdef SPI_CTRL_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full  <= 1'b0;
            hold_frame <= '0;
        end else begin
            hold_full  <= hold_full_d;
            hold_frame <= hold_frame_d;
        end
    end
`endif

    assign sclk = sclk_q;
    assign ncs  = ncs_q;
    assign copi = copi_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed self-checking bench for spi_controller

module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       req_rw;
    logic       sclk, ncs, copi, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Peripheral model and pin monitor state
    logic [7:0]  regs [0:4];
    logic        prev_sclk = 1'b0, prev_ncs = 1'b1, prev_copi = 1'b0, prev_rst = 1'b0;
    int          copi_stable = 0, since_rise = 100;
    int          sl_bits = 0;
    logic [15:0] sl_shift = '0;
    int          low_len = 0, high_len = 0, last_low_len = 0, last_high_len = 0;
    logic [15:0] last_frame = '0;
    int          last_edges = 0, frames_seen = 0, done_count = 0;
    int          viol_setup = 0, viol_hold = 0, viol_sclk = 0, viol_ncs = 0;
    int          viol_done = 0, viol_ready = 0;

    always #5 clk = ~clk;

    spi_controller #(
        .CLK_DIV (2),
        .CS_SETUP(2),
        .CS_HOLD (2),
        .IDLE_GAP(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_rw   (req_rw),
        .sclk     (sclk),
        .ncs      (ncs),
        .copi     (copi),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) regs[i] = 8'h00;
        forever begin
            logic mon;
            @(negedge clk);
            mon = rst_n && prev_rst;
            if (copi != prev_copi) copi_stable = 1;
            else copi_stable++;
            since_rise++;
            if (ncs && !prev_ncs) begin
                last_low_len = low_len;
                last_edges   = sl_bits;
                high_len     = 0;
                if (sl_bits == 16) begin
                    frames_seen++;
                    last_frame = sl_shift;
                    if (sl_shift[0] && sl_shift[7:1] <= 7'd4) regs[sl_shift[7:1]] = sl_shift[15:8];
                end
            end
            if (!ncs && prev_ncs) begin
                last_high_len = high_len;
                low_len  = 0;
                sl_bits  = 0;
                sl_shift = '0;
            end
            if (ncs) high_len++;
            else low_len++;
            if (sclk && !prev_sclk) begin
                since_rise = 0;
                if (!ncs) begin
                    sl_shift = {sl_shift[14:0], copi};
                    sl_bits++;
                end
                if (mon && copi_stable < 3) viol_setup++;
            end
            if (mon && !ncs && !prev_ncs && copi != prev_copi && since_rise < 2) viol_hold++;
            if (mon && sclk != prev_sclk && (ncs || prev_ncs)) viol_sclk++;
            if (mon && ncs != prev_ncs && (sclk || prev_sclk)) viol_ncs++;
            if (done) begin
                done_count++;
                if (!(mon && ncs && !prev_ncs)) viol_done++;
            end
`ifndef SPI_CTRL_QUEUE_EN
            if (mon && busy && req_ready) viol_ready++;
`endif
            prev_sclk = sclk;
            prev_ncs  = ncs;
            prev_copi = copi;
            prev_rst  = rst_n;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [6:0] a, input logic [7:0] d, input logic rw);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_rw    = rw;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 7'h7f;
        req_data  = 8'h00;
        req_rw    = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        check_eq("idle_wait", busy, 0);
    endtask

    logic [7:0]  sweep_data  [0:3];
    logic [15:0] sweep_frame [0:3];
    int d0, f0, n;

    initial begin
        sweep_data[0]  = 8'h3C; sweep_frame[0] = 16'h3C01;
        sweep_data[1]  = 8'hC3; sweep_frame[1] = 16'hC303;
        sweep_data[2]  = 8'hFF; sweep_frame[2] = 16'hFF05;
        sweep_data[3]  = 8'h01; sweep_frame[3] = 16'h0107;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_rw    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_ncs", ncs, 1);
        check_eq("rst_copi", copi, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ready", req_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", req_ready, 1);

        // Write pwm register: addr 0x04, data 0xA5 -> frame 0xA509
        d0 = done_count;
        f0 = frames_seen;
        send(7'h04, 8'hA5, 1'b1);
        check_eq("busy_after_accept", busy, 1);
        wait_idle();
        check_eq("a509_frame", last_frame, 16'hA509);
        check_eq("a509_edges", last_edges, 16);
        check_eq("a509_ncs_low", last_low_len, 68);
        check_eq("a509_done", done_count - d0, 1);
        check_eq("a509_frames", frames_seen - f0, 1);
        check_eq("pwm_reg", regs[4], 8'hA5);

        for (int i = 0; i < 4; i++) begin
            send(7'(i), sweep_data[i], 1'b1);
            wait_idle();
            check_eq("sweep_frame", last_frame, sweep_frame[i]);
            check_eq("sweep_reg", regs[i], sweep_data[i]);
        end

        // rw=0 frame must not write the peripheral
        send(7'h00, 8'h77, 1'b0);
        wait_idle();
        check_eq("read_frame", last_frame, 16'h7700);
        check_eq("read_no_write", regs[0], 8'h3C);

`ifndef SPI_CTRL_QUEUE_EN
        // Second request held off until IDLE
        d0 = done_count;
        send(7'h02, 8'h11, 1'b1);
        req_valid = 1'b1;
        req_addr  = 7'h03;
        req_data  = 8'h22;
        req_rw    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("pend_ready", req_ready, 1);
        check_eq("pend_busy_low", busy, 0);
        check_eq("pend_wait_long", (n >= 68), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle();
        check_eq("pend_reg2", regs[2], 8'h11);
        check_eq("pend_reg3", regs[3], 8'h22);
        check_eq("pend_gap", (last_high_len >= 3), 1);
        check_eq("pend_done", done_count - d0, 2);
`else
        // Two requests on consecutive cycles, back-to-back frames
        d0 = done_count;
        f0 = frames_seen;
        send(7'h02, 8'h11, 1'b1);
        req_valid = 1'b1;
        req_addr  = 7'h03;
        req_data  = 8'h22;
        req_rw    = 1'b1;
        @(negedge clk);
        check_eq("q_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 7'h7f;
        check_eq("q_full_ready", req_ready, 0);
        wait_idle();
        check_eq("q_frames", frames_seen - f0, 2);
        check_eq("q_reg2", regs[2], 8'h11);
        check_eq("q_reg3", regs[3], 8'h22);
        check_eq("q_gap", last_high_len, 3);
        check_eq("q_done", done_count - d0, 2);
`endif

        // Reset in the middle of SHIFT
        d0 = done_count;
        f0 = frames_seen;
        send(7'h01, 8'h55, 1'b1);
        repeat (10) @(negedge clk);
        n = 0;
        while (!sclk && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_sclk_high", sclk, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_ncs", ncs, 1);
        check_eq("abort_sclk", sclk, 0);
        check_eq("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_ready", req_ready, 1);
        repeat (4) @(negedge clk);
        check_eq("abort_no_done", done_count - d0, 0);
        check_eq("abort_no_frame", frames_seen - f0, 0);
        check_eq("abort_reg1", regs[1], 8'hC3);

        send(7'h01, 8'h5A, 1'b1);
        wait_idle();
        check_eq("recover_reg1", regs[1], 8'h5A);
        check_eq("recover_ncs_low", last_low_len, 68);

        check_eq("copi_setup", viol_setup, 0);
        check_eq("copi_hold", viol_hold, 0);
        check_eq("sclk_ncs_high", viol_sclk, 0);
        check_eq("ncs_sclk_high", viol_ncs, 0);
        check_eq("done_align", viol_done, 0);
        check_eq("ready_busy", viol_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
